rename_ckpt: RTL and testbench

Parametrised successor to the single-issue renamer.
- Maps architectural registers to physical registers through a RAT and a circular FIFO free list.
- Recycles the stale physical register of each committed instruction.
- Holds up to NUM_CKPT outstanding branch checkpoints for single-cycle misprediction recovery.
- Sits between decode and dispatch, with valid/ready handshakes on both sides and one registered output stage.

---
 rtl/rename_pkg.sv | 34 +++
 rtl/rename_ckpt_if.sv | 49 ++++
 rtl/rename_free_fifo.sv | 74 +++++++
 rtl/rename_ckpt.sv | 211 +++++++++++++++++++++
 tb/tb_rename_ckpt.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared sizing, derived widths and operand types for the checkpointing renamer.
// The renamer is re-sized by editing the three base parameters here; every
// other width in the design is derived from them.
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int NUM_CKPT = 4;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AREG_W     = idx_w(NUM_ARCH);
  localparam int PREG_W     = idx_w(NUM_PHYS);
  localparam int CKPT_W     = idx_w(NUM_CKPT);
  localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;
  // Free-list pointers carry one extra wrap bit above the slot index.
  localparam int FPTR_W     = idx_w(FREE_DEPTH) + 1;
  localparam int CPTR_W     = CKPT_W + 1;

  typedef struct packed {
    logic              valid;
    logic [AREG_W-1:0] idx;
  } areg_t;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [PREG_W-1:0] idx;
  } preg_t;

endpackage

// File: rtl/rename_ckpt_if.sv
// Decode-side, dispatch-side and pipeline-feedback signals of the renamer.
// Signal suffixes are written from the renamer's point of view.
interface rename_ckpt_if;
  import rename_pkg::*;

  // decode side
  logic              in_valid_i;
  logic              in_ready_o;
  areg_t             in_rs1_i;
  areg_t             in_rs2_i;
  areg_t             in_rd_i;
  logic              in_is_branch_i;
  // dispatch side
  logic              out_valid_o;
  logic              out_ready_i;
  preg_t             out_rs1_o;
  preg_t             out_rs2_o;
  preg_t             out_rd_o;
  logic [PREG_W-1:0] out_rd_old_o;
  logic [CKPT_W-1:0] out_ckpt_o;
  // writeback, commit and branch resolution
  logic              wb_valid_i;
  logic [PREG_W-1:0] wb_preg_i;
  logic              free_valid_i;
  logic [PREG_W-1:0] free_preg_i;
  logic              br_valid_i;
  logic              br_mispredict_i;

  // The renamer itself.
  modport slave (
    input  in_valid_i, in_rs1_i, in_rs2_i, in_rd_i, in_is_branch_i,
    output in_ready_o,
    output out_valid_o, out_rs1_o, out_rs2_o, out_rd_o, out_rd_old_o, out_ckpt_o,
    input  out_ready_i,
    input  wb_valid_i, wb_preg_i, free_valid_i, free_preg_i,
    input  br_valid_i, br_mispredict_i
  );

  // The surrounding pipeline driving the renamer.
  modport master (
    output in_valid_i, in_rs1_i, in_rs2_i, in_rd_i, in_is_branch_i,
    input  in_ready_o,
    input  out_valid_o, out_rs1_o, out_rs2_o, out_rd_o, out_rd_old_o, out_ckpt_o,
    output out_ready_i,
    output wb_valid_i, wb_preg_i, free_valid_i, free_preg_i,
    output br_valid_i, br_mispredict_i
  );

endinterface

// File: rtl/rename_free_fifo.sv
// Circular free list of physical registers. Pops from head for allocation,
// pushes committed stale registers at tail, and lets the head be rewound to a
// checkpointed pointer on misprediction. Storage rounds up to a power of two
// so the wrap-bit pointer arithmetic holds for any DEPTH.
module rename_free_fifo #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6,
  parameter int BASE   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        pop_i,
  input  logic                        push_i,
  input  logic [PREG_W-1:0]           push_preg_i,
  input  logic                        restore_i,
  input  logic [$clog2(DEPTH):0]      restore_ptr_i,
  output logic [PREG_W-1:0]           head_preg_o,
  output logic [$clog2(DEPTH):0]      head_ptr_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int STORE = 2 ** IDX_W;

  logic [PREG_W-1:0] mem_q [STORE];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;

  assign head_preg_o = mem_q[head_q[IDX_W-1:0]];
  assign head_ptr_o  = head_q;
  assign count_o     = tail_q - head_q;

  // Pointer advance; a restore takes precedence over a pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (restore_i) begin
      head_d = restore_ptr_i;
    end else if (pop_i) begin
      head_d = head_q + 1'b1;
    end
    if (push_i) begin
      tail_d = tail_q + 1'b1;
    end
  end

  // Storage and pointers; reset fills the list with the registers above the
  // architectural identity mapping, so the list starts full.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < STORE; i++) begin
        mem_q[i] <= (i < DEPTH) ? PREG_W'(BASE + i) : '0;
      end
      head_q <= '0;
      tail_q <= PTR_W'(DEPTH);
    end else begin
      if (push_i) begin
        mem_q[tail_q[IDX_W-1:0]] <= push_preg_i;
      end
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // p0 backs x0 and is never released; a full list cannot take another entry.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i) begin
      assert (push_preg_i != '0);
      assert (count_o < PTR_W'(DEPTH));
    end
  end

endmodule

// File: rtl/rename_ckpt.sv
// Single-issue register renamer with branch checkpoints. Sources are looked up
// in the RAT, destinations take a fresh register from the free list, and each
// branch snapshots the RAT plus free-list head so a misprediction rolls back
// in one cycle. One registered output stage faces dispatch.
module rename_ckpt
  import rename_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  rename_ckpt_if.slave bus
);

  // Speculative mapping, checkpoint copies and per-register ready bits.
  logic [PREG_W-1:0] rat_q      [NUM_ARCH];
  logic [PREG_W-1:0] rat_d      [NUM_ARCH];
  logic [PREG_W-1:0] ckpt_rat_q [NUM_CKPT][NUM_ARCH];
  logic [FPTR_W-1:0] ckpt_fhead_q [NUM_CKPT];
  logic [NUM_PHYS-1:0] rdy_q, rdy_d;

  logic [CPTR_W-1:0] ckpt_head_q, ckpt_head_d;
  logic [CPTR_W-1:0] ckpt_tail_q, ckpt_tail_d;
  logic [CPTR_W-1:0] ckpt_count, ckpt_count_eff;
  logic [CKPT_W-1:0] ckpt_head_idx, ckpt_tail_idx;

  logic [PREG_W-1:0] free_head_preg;
  logic [FPTR_W-1:0] free_head_ptr;
  logic [FPTR_W-1:0] free_count;

  logic br_ok, br_miss, alloc, in_ready, fire, do_alloc, do_ckpt;

  // Output stage.
  logic              out_valid_q;
  preg_t             out_rs1_q, out_rs1_d;
  preg_t             out_rs2_q, out_rs2_d;
  preg_t             out_rd_q, out_rd_d;
  logic [PREG_W-1:0] out_rd_old_q, out_rd_old_d;
  logic [CKPT_W-1:0] out_ckpt_q, out_ckpt_d;

  // Checkpoint slot addressed by a wrap-bit pointer.
  function automatic logic [CKPT_W-1:0] slot(input logic [CPTR_W-1:0] p);
    return p[CKPT_W-1:0] & CKPT_W'(NUM_CKPT - 1);
  endfunction

  // Source lookup against the pre-update RAT, with same-cycle writeback bypass.
  function automatic preg_t rename_src(input areg_t a);
    preg_t             p;
    logic [PREG_W-1:0] m;
    p = '0;
    m = rat_q[a.idx];
    if (a.valid) begin
      p.valid = 1'b1;
      if (a.idx == '0) begin
        p.ready = 1'b1;
      end else begin
        p.idx   = m;
        p.ready = rdy_q[m] | (bus.wb_valid_i && (bus.wb_preg_i == m));
      end
    end
    return p;
  endfunction

  rename_free_fifo #(
    .DEPTH (FREE_DEPTH),
    .PREG_W(PREG_W),
    .BASE  (NUM_ARCH)
  ) u_free (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pop_i        (do_alloc),
    .push_i       (bus.free_valid_i),
    .push_preg_i  (bus.free_preg_i),
    .restore_i    (br_miss),
    .restore_ptr_i(ckpt_fhead_q[ckpt_head_idx]),
    .head_preg_o  (free_head_preg),
    .head_ptr_o   (free_head_ptr),
    .count_o      (free_count)
  );

  // Handshake: resolution is applied before the fire decision, so a correctly
  // predicted branch frees its checkpoint slot for a branch firing this cycle.
  always_comb begin
    br_ok          = bus.br_valid_i && !bus.br_mispredict_i;
    br_miss        = bus.br_valid_i && bus.br_mispredict_i;
    alloc          = bus.in_rd_i.valid && (bus.in_rd_i.idx != '0);
    ckpt_count     = ckpt_tail_q - ckpt_head_q;
    ckpt_count_eff = ckpt_count - CPTR_W'(br_ok);
    ckpt_head_idx  = slot(ckpt_head_q);
    ckpt_tail_idx  = slot(ckpt_tail_q);
    in_ready = rst_ni
            && (!out_valid_q || bus.out_ready_i)
            && !(alloc && (free_count == '0))
            && !(bus.in_is_branch_i && (ckpt_count_eff == CPTR_W'(NUM_CKPT)))
            && !br_miss;
    fire     = bus.in_valid_i && in_ready;
    do_alloc = fire && alloc;
    do_ckpt  = fire && bus.in_is_branch_i;
  end

  // Next RAT, ready bits and checkpoint pointers.
  always_comb begin
    for (int i = 0; i < NUM_ARCH; i++) begin
      rat_d[i] = rat_q[i];
    end
    if (br_miss) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat_d[i] = ckpt_rat_q[ckpt_head_idx][i];
      end
    end else if (do_alloc) begin
      rat_d[bus.in_rd_i.idx] = free_head_preg;
    end

    rdy_d = rdy_q;
    if (bus.wb_valid_i) begin
      rdy_d[bus.wb_preg_i] = 1'b1;
    end
    if (do_alloc) begin
      rdy_d[free_head_preg] = 1'b0;
    end

    ckpt_head_d = ckpt_head_q;
    if (br_miss) begin
      ckpt_head_d = ckpt_tail_q;
    end else if (br_ok) begin
      ckpt_head_d = ckpt_head_q + 1'b1;
    end
    ckpt_tail_d = ckpt_tail_q + CPTR_W'(do_ckpt);
  end

  // Renamed fields presented to the output stage on a fire.
  always_comb begin
    out_rs1_d    = rename_src(bus.in_rs1_i);
    out_rs2_d    = rename_src(bus.in_rs2_i);
    out_rd_d     = '0;
    out_rd_old_d = '0;
    if (alloc) begin
      out_rd_d.valid = 1'b1;
      out_rd_d.idx   = free_head_preg;
      out_rd_old_d   = rat_q[bus.in_rd_i.idx];
    end else if (bus.in_rd_i.valid) begin
      out_rd_d.valid = 1'b1;
      out_rd_d.ready = 1'b1;
    end
    out_ckpt_d = bus.in_is_branch_i ? ckpt_tail_idx : '0;
  end

  // Mapping state; a branch snapshots the RAT including its own rd update and
  // the free-list head after its own pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat_q[i] <= PREG_W'(i);
      end
      for (int c = 0; c < NUM_CKPT; c++) begin
        for (int i = 0; i < NUM_ARCH; i++) begin
          ckpt_rat_q[c][i] <= PREG_W'(i);
        end
        ckpt_fhead_q[c] <= '0;
      end
      for (int p = 0; p < NUM_PHYS; p++) begin
        rdy_q[p] <= (p < NUM_ARCH);
      end
      ckpt_head_q <= '0;
      ckpt_tail_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat_q[i] <= rat_d[i];
      end
      if (do_ckpt) begin
        for (int i = 0; i < NUM_ARCH; i++) begin
          ckpt_rat_q[ckpt_tail_idx][i] <= rat_d[i];
        end
        ckpt_fhead_q[ckpt_tail_idx] <= free_head_ptr + FPTR_W'(do_alloc);
      end
      rdy_q       <= rdy_d;
      ckpt_head_q <= ckpt_head_d;
      ckpt_tail_q <= ckpt_tail_d;
    end
  end

  // Output stage: load on fire, hold under back-pressure, drop on mispredict.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_rd_q     <= '0;
      out_rd_old_q <= '0;
      out_ckpt_q   <= '0;
    end else if (br_miss) begin
      out_valid_q <= 1'b0;
    end else if (fire) begin
      out_valid_q  <= 1'b1;
      out_rs1_q    <= out_rs1_d;
      out_rs2_q    <= out_rs2_d;
      out_rd_q     <= out_rd_d;
      out_rd_old_q <= out_rd_old_d;
      out_ckpt_q   <= out_ckpt_d;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_rs1_o    = out_rs1_q;
  assign bus.out_rs2_o    = out_rs2_q;
  assign bus.out_rd_o     = out_rd_q;
  assign bus.out_rd_old_o = out_rd_old_q;
  assign bus.out_ckpt_o   = out_ckpt_q;

endmodule

// File: tb/tb_rename_ckpt.sv
// Directed bench for rename_ckpt: allocation, free-list wrap, checkpoint
// recovery, checkpoint-full stall, writeback bypass, back-pressure and reset.
module tb_rename_ckpt;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rename_ckpt_if bus();

  rename_ckpt dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic areg_t ar(input int r);
    areg_t a;
    a = '0;
    if (r >= 0) begin
      a.valid = 1'b1;
      a.idx   = AREG_W'(r);
    end
    return a;
  endfunction

  function automatic preg_t mk_p(input bit v, input bit rdy, input int idx);
    preg_t p;
    p.valid = v;
    p.ready = rdy;
    p.idx   = PREG_W'(idx);
    return p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit br);
    bus.in_valid_i     = v;
    bus.in_rs1_i       = ar(rs1);
    bus.in_rs2_i       = ar(rs2);
    bus.in_rd_i        = ar(rd);
    bus.in_is_branch_i = br;
  endtask

  task automatic clear_inputs;
    drive(1'b0, -1, -1, -1, 1'b0);
    bus.out_ready_i     = 1'b1;
    bus.wb_valid_i      = 1'b0;
    bus.wb_preg_i       = '0;
    bus.free_valid_i    = 1'b0;
    bus.free_preg_i     = '0;
    bus.br_valid_i      = 1'b0;
    bus.br_mispredict_i = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();

    // ---- reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd_o), 32'd0);
    bus.in_valid_i = 1'b1;
    settle();
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);

    // ---- add x5,x1,x2 then a second write of x5
    rst_n = 1'b1;
    drive(1'b1, 1, 2, 5, 1'b0);
    settle();
    chk("a_in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    chk("a_out_valid", 32'(bus.out_valid_o), 32'd1);
    chk("a_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 1, 1)));
    chk("a_rs2", 32'(bus.out_rs2_o), 32'(mk_p(1, 1, 2)));
    chk("a_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 32)));
    chk("a_rd_old", 32'(bus.out_rd_old_o), 32'd5);
    drive(1'b1, 5, -1, 5, 1'b0);
    tick();
    chk("a2_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 0, 32)));
    chk("a2_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 33)));
    chk("a2_rd_old", 32'(bus.out_rd_old_o), 32'd32);
    drive(1'b0, -1, -1, -1, 1'b0);
    tick();
    chk("a_drain", 32'(bus.out_valid_o), 32'd0);

    // ---- exhaust the free list, then refill with p5 across the wrap
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, -1, -1, (i % 31) + 1, 1'b0);
      tick();
    end
    chk("b_last_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 63)));
    chk("b_last_old", 32'(bus.out_rd_old_o), 32'd32);
    drive(1'b1, -1, -1, 2, 1'b0);
    bus.free_valid_i = 1'b1;
    bus.free_preg_i  = PREG_W'(5);
    settle();
    chk("b_empty_stall", 32'(bus.in_ready_o), 32'd0);
    tick();
    bus.free_valid_i = 1'b0;
    chk("b_stall_valid", 32'(bus.out_valid_o), 32'd0);
    settle();
    chk("b_unstall", 32'(bus.in_ready_o), 32'd1);
    tick();
    chk("b_wrap_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 5)));
    chk("b_wrap_old", 32'(bus.out_rd_old_o), 32'd33);

    // ---- checkpoint then mispredict
    do_reset();
    drive(1'b1, 1, -1, 2, 1'b0);
    tick();
    chk("c_pre_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 32)));
    drive(1'b1, 2, -1, -1, 1'b1);
    tick();
    chk("c_br_ckpt", 32'(bus.out_ckpt_o), 32'd0);
    chk("c_br_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 0, 32)));
    drive(1'b1, -1, -1, 3, 1'b0);
    tick();
    chk("c_x3_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 33)));
    drive(1'b1, -1, -1, 4, 1'b0);
    tick();
    chk("c_x4_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 34)));
    drive(1'b1, -1, -1, 5, 1'b0);
    bus.br_valid_i      = 1'b1;
    bus.br_mispredict_i = 1'b1;
    settle();
    chk("c_miss_block", 32'(bus.in_ready_o), 32'd0);
    tick();
    bus.br_valid_i      = 1'b0;
    bus.br_mispredict_i = 1'b0;
    chk("c_miss_valid", 32'(bus.out_valid_o), 32'd0);
    drive(1'b1, 3, 4, 6, 1'b0);
    tick();
    chk("c_rec_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 1, 3)));
    chk("c_rec_rs2", 32'(bus.out_rs2_o), 32'(mk_p(1, 1, 4)));
    chk("c_rec_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 33)));
    chk("c_rec_old", 32'(bus.out_rd_old_o), 32'd6);

    // ---- checkpoint-full stall and same-cycle resolution
    do_reset();
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 1, -1, -1, 1'b1);
      tick();
      chk($sformatf("d_ckpt%0d", b), 32'(bus.out_ckpt_o), 32'(b));
    end
    settle();
    chk("d_full_stall", 32'(bus.in_ready_o), 32'd0);
    bus.br_valid_i = 1'b1;
    settle();
    chk("d_resolve_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    bus.br_valid_i = 1'b0;
    chk("d_wrap_valid", 32'(bus.out_valid_o), 32'd1);
    chk("d_wrap_ckpt", 32'(bus.out_ckpt_o), 32'd0);
    settle();
    chk("d_full_again", 32'(bus.in_ready_o), 32'd0);

    // ---- writeback bypass and x0 destination
    do_reset();
    drive(1'b1, -1, -1, 7, 1'b0);
    tick();
    drive(1'b1, 7, 0, 0, 1'b0);
    tick();
    chk("e_nobyp_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 0, 32)));
    chk("e_x0_rs2", 32'(bus.out_rs2_o), 32'(mk_p(1, 1, 0)));
    chk("e_x0_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 1, 0)));
    chk("e_x0_old", 32'(bus.out_rd_old_o), 32'd0);
    drive(1'b1, 7, -1, -1, 1'b0);
    bus.wb_valid_i = 1'b1;
    bus.wb_preg_i  = PREG_W'(32);
    tick();
    bus.wb_valid_i = 1'b0;
    chk("e_byp_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 1, 32)));
    tick();
    chk("e_sticky_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 1, 32)));

    // ---- back-pressure hold, then reset mid-stall
    drive(1'b1, -1, -1, 8, 1'b0);
    tick();
    chk("f_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 33)));
    bus.out_ready_i = 1'b0;
    drive(1'b1, -1, -1, 9, 1'b0);
    for (int s = 0; s < 3; s++) begin
      settle();
      chk($sformatf("f_stall_rdy%0d", s), 32'(bus.in_ready_o), 32'd0);
      tick();
      chk($sformatf("f_hold_valid%0d", s), 32'(bus.out_valid_o), 32'd1);
      chk($sformatf("f_hold_rd%0d", s), 32'(bus.out_rd_o), 32'(mk_p(1, 0, 33)));
    end
    rst_n = 1'b0;
    tick();
    chk("f_rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("f_rst_rd", 32'(bus.out_rd_o), 32'd0);
    chk("f_rst_ready", 32'(bus.in_ready_o), 32'd0);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    drive(1'b1, 5, 8, 9, 1'b0);
    tick();
    chk("f_id_rs1", 32'(bus.out_rs1_o), 32'(mk_p(1, 1, 5)));
    chk("f_id_rs2", 32'(bus.out_rs2_o), 32'(mk_p(1, 1, 8)));
    chk("f_id_rd", 32'(bus.out_rd_o), 32'(mk_p(1, 0, 32)));
    chk("f_id_old", 32'(bus.out_rd_old_o), 32'd9);
    drive(1'b0, -1, -1, -1, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
